// File: rtl/guard_sprite_fetch.sv
// Guard sprite pixel fetch: box test, mirrored/animated ROM addressing and a
// 3-cycle registered pipeline delivering palette index, hit and valid.
module guard_sprite_fetch #(
    parameter int SPR_W      = 32,
    parameter int SPR_H      = 48,
    parameter int FRAMES     = 2,
    parameter int ANIM_DIV   = 8,
    parameter int ROM_AW     = 12,
    parameter int TRANSP_IDX = 0,
    localparam int FW        = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_start,
    input  logic              walking,
    input  logic              facing_right,
    input  logic              pix_valid,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        guard_x,
    input  logic [9:0]        guard_y,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic [3:0]        index_out,
    output logic              hit_out,
    output logic              out_valid,
    output logic [FW-1:0]     anim_frame
);

    localparam int          CW         = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int          FRAME_SZ   = SPR_W * SPR_H;
    localparam logic [10:0] SPR_W_L    = 11'(SPR_W);
    localparam logic [10:0] SPR_H_L    = 11'(SPR_H);
    localparam logic [CW-1:0] CNT_LAST = CW'(ANIM_DIV - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(FRAMES - 1);
    localparam logic [3:0]  TRANSP_L   = 4'(TRANSP_IDX);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WALK = 1'b1} state_t;

    state_t            r_state, w_state_nxt;
    logic [CW-1:0]     r_cnt, w_cnt_nxt;
    logic [FW-1:0]     r_frame, w_frame_nxt;
    logic              r_facing, w_facing_nxt;

    logic [ROM_AW-1:0] r_rom_addr;
    logic              r_inside1, r_valid1, r_inside2, r_valid2;
    logic [3:0]        r_index;
    logic              r_hit, r_out_valid;

    logic [10:0]       w_rx, w_ry, w_col;
    logic              w_inside;
    logic [ROM_AW-1:0] w_addr;

    // Negative offsets wrap to large unsigned values and so fall outside the box.
    assign w_rx     = {1'b0, DrawX} - {1'b0, guard_x};
    assign w_ry     = {1'b0, DrawY} - {1'b0, guard_y};
    assign w_inside = pix_valid & (w_rx < SPR_W_L) & (w_ry < SPR_H_L);
    assign w_col    = r_facing ? (SPR_W_L - 11'd1 - w_rx) : w_rx;
    assign w_addr   = ROM_AW'(r_frame) * ROM_AW'(FRAME_SZ)
                    + ROM_AW'(w_ry) * ROM_AW'(SPR_W) + ROM_AW'(w_col);

    // Animation/facing next-state: only frame_start cycles may change anything.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_frame_nxt  = r_frame;
        w_facing_nxt = r_facing;
        if (frame_start) begin
            w_facing_nxt = facing_right;
            case (r_state)
                ST_IDLE: begin
                    w_cnt_nxt   = {CW{1'b0}};
                    w_frame_nxt = {FW{1'b0}};
                    if (walking) w_state_nxt = ST_WALK;
                    else         w_state_nxt = ST_IDLE;
                end
                ST_WALK: begin
                    if (!walking) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = {CW{1'b0}};
                        w_frame_nxt = {FW{1'b0}};
                    end else if (r_cnt == CNT_LAST) begin
                        w_cnt_nxt   = {CW{1'b0}};
                        w_frame_nxt = (r_frame == FRM_LAST) ? {FW{1'b0}} : r_frame + FW'(1);
                    end else begin
                        w_cnt_nxt   = r_cnt + CW'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = {CW{1'b0}};
                    w_frame_nxt = {FW{1'b0}};
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Animation/facing state registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= {CW{1'b0}};
            r_frame  <= {FW{1'b0}};
            r_facing <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_frame  <= w_frame_nxt;
            r_facing <= w_facing_nxt;
        end
    end

    // Fetch pipeline: address stage, ROM wait stage, output stage.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rom_addr  <= {ROM_AW{1'b0}};
            r_inside1   <= 1'b0;
            r_valid1    <= 1'b0;
            r_inside2   <= 1'b0;
            r_valid2    <= 1'b0;
            r_index     <= 4'd0;
            r_hit       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_rom_addr  <= w_inside ? w_addr : {ROM_AW{1'b0}};
            r_inside1   <= w_inside;
            r_valid1    <= pix_valid;
            r_inside2   <= r_inside1;
            r_valid2    <= r_valid1;
            r_index     <= r_inside2 ? rom_data : TRANSP_L;
            r_hit       <= r_inside2 & (rom_data != TRANSP_L);
            r_out_valid <= r_valid2;
        end
    end

    assign rom_addr   = r_rom_addr;
    assign index_out  = r_index;
    assign hit_out    = r_hit;
    assign out_valid  = r_out_valid;
    assign anim_frame = r_frame;

endmodule
